// File: rtl/mem_sys_bus_if.sv
// Bus between the RiSC-16 core data port and mem_sys_bus, plus the I/O and error pins.
// The master side is the core (and the pins it drives); the slave side is the memory subsystem.
interface mem_sys_bus_if;
  logic        i_req;
  logic        i_we;
  logic [15:0] i_addr;
  logic [15:0] i_wr_data;
  logic        o_ack;
  logic [15:0] o_rd_data;
  logic [15:0] i_io_in;
  logic [15:0] o_io_out;
  logic        o_err;
  logic [15:0] o_err_addr;

  modport master (
    output i_req, i_we, i_addr, i_wr_data, i_io_in,
    input  o_ack, o_rd_data, o_io_out, o_err, o_err_addr
  );

  modport slave (
    input  i_req, i_we, i_addr, i_wr_data, i_io_in,
    output o_ack, o_rd_data, o_io_out, o_err, o_err_addr
  );
endinterface

// File: rtl/mem_sys_bus.sv
// Data-side memory subsystem: req/ack bus, RAM with wait states, memory-mapped I/O page.
// Define MEM_SYS_ERR_EN to enable the sticky unmapped-access flag and its ERR_CLR register.
module mem_sys_bus #(
  parameter int          p_DATA_ADDR_LEN = 10,
  parameter int          p_WAIT          = 0,
  parameter logic [15:0] p_IO_BASE       = 16'hFF00,
  parameter string       p_INIT_FILE     = ""
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  mem_sys_bus_if.slave bus
);

  localparam int unsigned RAM_WORDS = 32'd1 << p_DATA_ADDR_LEN;
  localparam logic [3:0]  WAIT_LAST = 4'(p_WAIT - 1);
  localparam logic [15:0] IO_OUT_A  = p_IO_BASE;
  localparam logic [15:0] IO_IN_A   = p_IO_BASE + 16'd1;
  localparam logic [15:0] CYC_LO_A  = p_IO_BASE + 16'd2;
  localparam logic [15:0] CYC_HI_A  = p_IO_BASE + 16'd3;

  if (32'(p_IO_BASE) < RAM_WORDS) begin : g_overlap_check
    $error("mem_sys_bus: I/O page overlaps RAM");
  end
  if (p_WAIT < 0 || p_WAIT > 15) begin : g_wait_check
    $error("mem_sys_bus: p_WAIT out of range 0..15");
  end
  if (p_DATA_ADDR_LEN < 1 || p_DATA_ADDR_LEN > 16) begin : g_len_check
    $error("mem_sys_bus: p_DATA_ADDR_LEN out of range 1..16");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  wait_cnt_reg, wait_cnt_next;
  logic        commit;

  logic [15:0] ram_mem [RAM_WORDS];
  logic [15:0] ram_rd_reg;
  logic        ram_we, ram_re;
  logic [p_DATA_ADDR_LEN-1:0] ram_idx;

  logic [31:0] cyc_cnt_reg;
  logic [15:0] shadow_reg;
  logic [15:0] io_out_reg;
  logic [15:0] rd_other_reg;
  logic        rd_sel_ram_reg;
  logic [15:0] rd_mux;

  logic hit_ram, hit_io_out, hit_io_in, hit_cyc_lo, hit_cyc_hi;

  assign hit_ram    = (32'(bus.i_addr) < RAM_WORDS);
  assign hit_io_out = (bus.i_addr == IO_OUT_A);
  assign hit_io_in  = (bus.i_addr == IO_IN_A);
  assign hit_cyc_lo = (bus.i_addr == CYC_LO_A);
  assign hit_cyc_hi = (bus.i_addr == CYC_HI_A);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // commit marks the edge that enters ACK; all side effects of an access happen there
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    commit        = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (bus.i_req) begin
          wait_cnt_next = '0;
          if (p_WAIT == 0) begin
            state_next = ST_ACK;
            commit     = 1'b1;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_reg == WAIT_LAST) begin
          state_next = ST_ACK;
          commit     = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + 4'd1;
        end
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.o_ack = (state_reg == ST_ACK);

  assign ram_idx = bus.i_addr[p_DATA_ADDR_LEN-1:0];
  assign ram_we  = commit && i_rst_n && bus.i_we && hit_ram;
  assign ram_re  = commit && i_rst_n && !bus.i_we && hit_ram;

  // RAM kept free of reset so it maps onto block RAM with a registered read port
  always_ff @(posedge i_clk) begin
    if (ram_we) ram_mem[ram_idx] <= bus.i_wr_data;
    if (ram_re) ram_rd_reg <= ram_mem[ram_idx];
  end

  always_comb begin
    rd_mux = '0;
    if (hit_io_out)      rd_mux = io_out_reg;
    else if (hit_io_in)  rd_mux = bus.i_io_in;
    else if (hit_cyc_lo) rd_mux = cyc_cnt_reg[15:0];
    else if (hit_cyc_hi) rd_mux = shadow_reg;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cyc_cnt_reg    <= '0;
      shadow_reg     <= '0;
      io_out_reg     <= '0;
      rd_other_reg   <= '0;
      rd_sel_ram_reg <= 1'b0;
    end else begin
      cyc_cnt_reg <= cyc_cnt_reg + 32'd1;
      if (commit) begin
        if (bus.i_we) begin
          if (hit_io_out) io_out_reg <= bus.i_wr_data;
        end else begin
          rd_sel_ram_reg <= hit_ram;
          rd_other_reg   <= rd_mux;
          // latch the upper half so a following CYC_HI read is coherent
          if (hit_cyc_lo) shadow_reg <= cyc_cnt_reg[31:16];
        end
      end
    end
  end

  assign bus.o_rd_data = rd_sel_ram_reg ? ram_rd_reg : rd_other_reg;
  assign bus.o_io_out  = io_out_reg;

`ifdef MEM_SYS_ERR_EN
  localparam logic [15:0] ERR_CLR_A = p_IO_BASE + 16'd4;

  logic        hit_err_clr, unmapped;
  logic        err_reg;
  logic [15:0] err_addr_reg;

  assign hit_err_clr = (bus.i_addr == ERR_CLR_A);
  assign unmapped    = !(hit_ram || hit_io_out || hit_io_in || hit_cyc_lo || hit_cyc_hi || hit_err_clr);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      err_reg      <= 1'b0;
      err_addr_reg <= '0;
    end else if (commit) begin
      if (hit_err_clr && bus.i_we) begin
        err_reg      <= 1'b0;
        err_addr_reg <= '0;
      end else if (unmapped) begin
        err_reg <= 1'b1;
        if (!err_reg) err_addr_reg <= bus.i_addr;
      end
    end
  end

  assign bus.o_err      = err_reg;
  assign bus.o_err_addr = err_addr_reg;
`else
  assign bus.o_err      = 1'b0;
  assign bus.o_err_addr = '0;
`endif

endmodule

// File: tb/tb_mem_sys_bus.sv
// Randomised self-checking bench for mem_sys_bus against a transaction-level model.
// Honours MEM_SYS_ERR_EN when compiled with it.
module tb_mem_sys_bus;

  localparam int          P_WAIT = 2;
  localparam int          P_LEN  = 10;
  localparam logic [15:0] P_BASE = 16'hFF00;
  localparam int          RAM_WORDS = 1 << P_LEN;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   edge_no = 0;
  int   rst_edge = 0;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  mem_sys_bus_if bus ();

  mem_sys_bus #(
    .p_DATA_ADDR_LEN (P_LEN),
    .p_WAIT          (P_WAIT),
    .p_IO_BASE       (P_BASE),
    .p_INIT_FILE     ("")
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_no <= edge_no + 1;

  // model state
  logic [15:0] ram_m [RAM_WORDS];
  logic [15:0] io_out_m, shadow_m, rd_m, err_addr_m;
  logic        err_m;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h @edge %0d", tag, got, exp, edge_no);
    end
  endtask

  function automatic logic is_mapped(input logic [15:0] a);
    logic m;
    m = (int'(a) < RAM_WORDS) || (a >= P_BASE && a <= P_BASE + 16'd3);
`ifdef MEM_SYS_ERR_EN
    if (a == P_BASE + 16'd4) m = 1'b1;
`endif
    return m;
  endfunction

  task automatic model_reset();
    io_out_m = '0; shadow_m = '0; rd_m = '0; err_m = 1'b0; err_addr_m = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk_val({tag, "_rd"},      bus.o_rd_data, rd_m);
    chk_val({tag, "_io"},      bus.o_io_out, io_out_m);
    chk_val({tag, "_err"},     bus.o_err, err_m);
    chk_val({tag, "_erraddr"}, bus.o_err_addr, err_addr_m);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.i_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_edge = edge_no;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One complete bus transaction; checks latency, then all outputs in the ack cycle.
  task automatic access(input string tag, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    int          n;
    logic [31:0] cyc;
    logic [15:0] exp_rd;
    @(posedge clk); #1;
    bus.i_req     = 1'b1;
    bus.i_we      = we;
    bus.i_addr    = addr;
    bus.i_wr_data = wdata;
    bus.i_io_in   = 16'($urandom);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.o_ack && n < 40);
    chk_val({tag, "_lat"}, n, P_WAIT + 1);
    bus.i_req = 1'b0;
    // counter value just before the commit edge, counted from the last reset edge
    cyc = 32'(edge_no - rst_edge - 1);
    if (!we) begin
      exp_rd = 16'h0000;
      if (int'(addr) < RAM_WORDS)   exp_rd = ram_m[addr[P_LEN-1:0]];
      else if (addr == P_BASE)      exp_rd = io_out_m;
      else if (addr == P_BASE + 1)  exp_rd = bus.i_io_in;
      else if (addr == P_BASE + 2) begin
        exp_rd   = cyc[15:0];
        shadow_m = cyc[31:16];
      end
      else if (addr == P_BASE + 3)  exp_rd = shadow_m;
      rd_m = exp_rd;
    end else begin
      if (int'(addr) < RAM_WORDS) ram_m[addr[P_LEN-1:0]] = wdata;
      else if (addr == P_BASE)    io_out_m = wdata;
`ifdef MEM_SYS_ERR_EN
      if (addr == P_BASE + 16'd4) begin
        err_m = 1'b0;
        err_addr_m = '0;
      end
`endif
    end
`ifdef MEM_SYS_ERR_EN
    if (!is_mapped(addr)) begin
      if (!err_m) err_addr_m = addr;
      err_m = 1'b1;
    end
`endif
    check_outputs(tag);
    $display("%s we=%0d addr=%h wdata=%h rd=%h io_out=%h err=%0d", tag, we, addr, wdata,
             bus.o_rd_data, bus.o_io_out, bus.o_err);
  endtask

  initial begin
    int          t0, prev, acks, n;
    logic [15:0] a, d, lo1;
    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_addr = '0; bus.i_wr_data = '0; bus.i_io_in = '0;

    do_reset();
    chk_val("rst_ack", bus.o_ack, 1'b0);
    check_outputs("rst");

    // T4 first: counter read relative to reset
    access("t4_lo", 1'b0, P_BASE + 16'd2, 16'h0);
    lo1 = bus.o_rd_data;
    access("t4_hi", 1'b0, P_BASE + 16'd3, 16'h0);
    access("t4_lo2", 1'b0, P_BASE + 16'd2, 16'h0);
    chk_val("t4_delta", bus.o_rd_data - lo1, 16'(2 * (P_WAIT + 2)));

    // fill RAM so every later read has a known value
    for (int i = 0; i < RAM_WORDS; i++) access("fill", 1'b1, 16'(i), 16'($urandom));

    // T1
    access("t1_wr", 1'b1, 16'd5, 16'h1234);
    access("t1_rd", 1'b0, 16'd5, 16'h0);
    // T3
    access("t3_wr", 1'b1, P_BASE, 16'hA5A5);
    access("t3_wrin", 1'b1, P_BASE + 16'd1, 16'h7777);
    access("t3_rdin", 1'b0, P_BASE + 16'd1, 16'h0);
    access("t3_rdout", 1'b0, P_BASE, 16'h0);
    // T2
    access("t2_wr", 1'b1, 16'h0400, 16'hBEEF);
    access("t2_rd", 1'b0, 16'h0400, 16'h0);
    access("t2_rd0", 1'b0, 16'h0000, 16'h0);
    access("t2_bad2", 1'b0, 16'h0500, 16'h0);
    access("t2_clr", 1'b1, P_BASE + 16'd4, 16'h9999);

    // random traffic
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 16'($urandom_range(0, RAM_WORDS - 1));
        4:          a = 16'($urandom_range(RAM_WORDS - 4, RAM_WORDS + 4));
        5, 6, 7:    a = P_BASE + 16'($urandom_range(0, 5));
        default:    a = 16'($urandom);
      endcase
      access("rnd", 1'($urandom), a, 16'($urandom));
    end

    // T5: reset during WAIT aborts the write
    access("t5_pre", 1'b1, 16'd7, 16'h1111);
    @(posedge clk); #1;
    bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_addr = 16'd7; bus.i_wr_data = 16'h5555;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_edge = edge_no;
    rst_n = 1'b1;
    bus.i_req = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      chk_val("t5_noack", bus.o_ack, 1'b0);
      @(posedge clk); #1;
    end
    check_outputs("t5_post");
    access("t5_rd", 1'b0, 16'd7, 16'h0);

    // T6: request held high, each access executed once
    @(posedge clk); #1;
    t0 = edge_no;
    d = 16'h6A6A;
    bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_addr = 16'd9; bus.i_wr_data = d;
    acks = 0; n = 0; prev = t0;
    while (acks < 4 && n < 80) begin
      @(posedge clk); #1;
      n++;
      if (bus.o_ack) begin
        acks++;
        if (acks == 1) chk_val("t6_first", edge_no - t0, P_WAIT + 1);
        else           chk_val("t6_gap", edge_no - prev, P_WAIT + 2);
        prev = edge_no;
      end
    end
    chk_val("t6_acks", acks, 4);
    bus.i_req = 1'b0;
    ram_m[9] = d;
    access("t6_rd", 1'b0, 16'd9, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
